muldiv_unit: RTL
================

# muldiv_unit

Parametrised multi-cycle integer multiply/divide unit for the five-stage pipelined CPU, placed beside the Ex stage. It executes MULT/MULTU/DIV/DIVU into dedicated HI/LO registers. It exposes `busy` so the ID stage can stall MFHI/MFLO and any new mul/div issue until the result is ready.

## Interface
Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; must be an even number ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  issue request; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  operand A (multiplicand / dividend), i.e. busA.
- b  in  WIDTH  operand B (multiplier / divisor), i.e. busB.
- flush  in  1  abort the in-flight operation (branch/jump squash).
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; ID stalls on it.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE→PREP when start=1. Latch op. For signed ops, latch |a| and |b| plus the sign flags. For unsigned ops, latch a and b raw.
- PREP→RUN: clear the 2·WIDTH accumulator and load counter = WIDTH.
- RUN: one radix-2 step per cycle; counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add, 1 bit per cycle.
  - Divide: restoring division, 1 quotient bit per cycle.
- FIX: apply sign correction, write HI/LO, → IDLE.
- Multiply results:
  - {hi,lo} = full 2·WIDTH-bit product.
  - MULT: negate the product if sign(a)≠sign(b).
- Divide results:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = a. The iteration count is unchanged, so latency is the same as any other divide.
- DIV overflow (a = −2^(WIDTH−1), b = −1): lo = −2^(WIDTH−1) (wrap), hi = 0.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Idle: write wdata at the next edge.
  - Busy: ignored; ID guarantees the stall.
  - In the same cycle as an accepted start: the write is applied, and the operation's result overwrites it later.
- flush:
  - In PREP/RUN/FIX: return to IDLE at the next edge. HI/LO are not modified and done stays low.
  - In IDLE: no effect; it also suppresses a simultaneous start.
- Operands are captured at start; a/b may change afterwards.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation.
- busy is registered, equal to (state≠IDLE).
- Accepted start at edge E0 gives this sequence:
  - PREP: cycle E0→E1.
  - RUN: ends at edges E2…E(WIDTH+1).
  - FIX: ends at E(WIDTH+2). HI/LO take the result at that edge.
  - busy=1 from E0 to E(WIDTH+2).
  - done=1 for exactly the cycle after E(WIDTH+2); busy=0 in that cycle.
- Result latency: WIDTH+2 cycles, so 34 for WIDTH=32.
- Back-to-back: a new start may be accepted in the done cycle.
- MTHI/MTLO latency: 1 cycle.

## Test plan
- Reset then MULTU, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high for exactly 34 cycles.
- MULT a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI wdata=0x1234 while idle → hi=0x1234 next cycle. Start DIVU 9/4, then hold start=1 with op=MULTU and assert hi_we during busy → both ignored; final hi=1, lo=2.
- Start MULTU 5×6; flush at cycle 10 → busy=0 next cycle, done never pulses, hi/lo keep their prior values. An immediate new MULTU 5×6 → lo=30, hi=0.
- rst_n=0 at cycle 20 of a divide → hi=lo=0, busy=0 next cycle. Sweep random signed/unsigned operands at WIDTH=8 and WIDTH=32 against a reference model.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with dedicated HI/LO registers.
// Signed operations work on magnitudes (shift-add multiply, restoring divide)
// and apply the sign correction in the final FIX cycle.
// Handshake: start is taken only while busy is low; busy stays high until the
// result is written, and done pulses for one cycle right after HI/LO update.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sign_a, sign_b, b_zero;
    logic [2*WIDTH-1:0] acc;

    // One iteration of the datapath, plus the sign-corrected results.
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_fix;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush aborts any in-flight operation.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !flush) state_nx = PREP;
            PREP: state_nx = flush ? IDLE : RUN;
            RUN: begin
                if (flush)                   state_nx = IDLE;
                else if (cnt == CNT_W'(1))   state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single radix-2 step: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_addend = b_q[0] ? a_q : '0;
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        div_shift  = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ge     = (div_shift >= {1'b0, b_q});
        div_diff   = div_shift - {1'b0, b_q};
        if (op_q[1])
            step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        else
            step_acc = {mul_sum, acc[WIDTH-1:1]};
    end

    // Sign correction; divide-by-zero forces an all-ones quotient and the
    // remainder path naturally yields the original dividend.
    always_comb begin
        prod_fix = (op_q[0] && (sign_a ^ sign_b)) ? -acc : acc;
        if (op_q[1]) begin
            res_lo = b_zero ? '1
                   : ((sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        op_q   <= op;
                        sign_a <= op[0] & a[WIDTH-1];
                        sign_b <= op[0] & b[WIDTH-1];
                        a_q    <= (op[0] && a[WIDTH-1]) ? -a : a;
                        b_q    <= (op[0] && b[WIDTH-1]) ? -b : b;
                        b_zero <= (b == '0);
                    end
                end
                PREP: begin
                    acc <= '0;
                    cnt <= CNT_W'(WIDTH);
                end
                RUN: begin
                    acc <= step_acc;
                    cnt <= cnt - CNT_W'(1);
                    if (op_q[1]) a_q <= {a_q[WIDTH-2:0], 1'b0};
                    else         b_q <= {1'b0, b_q[WIDTH-1:1]};
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
